// File: rtl/rs_slot_allocator.sv
// rs_slot_allocator
// Occupancy owner for a DEPTH-entry reservation station. Offers the ALLOC_W
// lowest-index free slots to in-order dispatch lanes and retires slots that
// issue releases. Allocation and release both take effect at the next edge.
// The offer is never bypassed from same-cycle releases.
// Optional feature macro: RS_ALLOC_STATS_EN (adds stall_cycles, peak_occupancy).
module rs_slot_allocator #(
   parameter int DEPTH   = 8,
   parameter int ALLOC_W = 2,
   parameter int FREE_W  = 2,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [ALLOC_W-1:0]        alloc_req,
   output logic [ALLOC_W-1:0]        alloc_ready,
   output logic [ALLOC_W*IDX_W-1:0]  alloc_idx,
   input  logic [FREE_W-1:0]         free_valid,
   input  logic [FREE_W*IDX_W-1:0]   free_idx,
   output logic [DEPTH-1:0]          occupied,
   output logic [IDX_W:0]            free_count,
   output logic                      full,
   output logic                      empty,
   output logic                      double_free_err
`ifdef RS_ALLOC_STATS_EN
   ,
   output logic [31:0]               stall_cycles,
   output logic [IDX_W:0]            peak_occupancy
`endif
);

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   // Number of set bits in an occupancy vector.
   function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [IDX_W:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + {{IDX_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   logic [DEPTH-1:0] occ_r;
   logic [IDX_W:0]   cnt_r;
   logic             full_r;
   logic             empty_r;
   logic             dbl_err_r;

   logic [IDX_W-1:0] offer_idx_s [ALLOC_W];
   logic [IDX_W:0]   seen_s;
   logic             chain_s;
   logic [DEPTH-1:0] fire_mask_s;
   logic [DEPTH-1:0] free_mask_s;
   logic [FREE_W-1:0] match_s;
   logic             dbl_s;
   logic [DEPTH-1:0] occ_next_s;

   // Scan the registered mask for the first ALLOC_W zero bits, lowest index first.
   always_comb begin
      seen_s = '0;
      for (int k = 0; k < ALLOC_W; k++) begin
         offer_idx_s[k] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < ALLOC_W; k++) begin
            offer_idx_s[k] = (!occ_r[i] && (seen_s == (IDX_W+1)'(k))) ? IDX_W'(i)
                                                                       : offer_idx_s[k];
         end
         seen_s = seen_s + {{IDX_W{1'b0}}, ~occ_r[i]};
      end
   end

   // Per-lane readiness, offered index and in-order (prefix) fire mask.
   always_comb begin
      alloc_ready = '0;
      alloc_idx   = '0;
      fire_mask_s = '0;
      chain_s     = 1'b1;
      for (int k = 0; k < ALLOC_W; k++) begin
         alloc_ready[k] = (cnt_r > (IDX_W+1)'(k)) && !flush && !reset;
         alloc_idx[k*IDX_W +: IDX_W] = alloc_ready[k] ? offer_idx_s[k] : {IDX_W{1'b0}};
         chain_s = chain_s & alloc_req[k] & alloc_ready[k];
         fire_mask_s = fire_mask_s |
                       (chain_s ? (DEPTH'(1'b1) << offer_idx_s[k]) : {DEPTH{1'b0}});
      end
   end

   // Decode releases; releasing a free or out-of-range slot flags an error.
   always_comb begin
      free_mask_s = '0;
      match_s     = '0;
      dbl_s       = 1'b0;
      for (int p = 0; p < FREE_W; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            match_s[p] = match_s[p] |
                         (free_valid[p] && (free_idx[p*IDX_W +: IDX_W] == IDX_W'(i)));
            free_mask_s[i] = free_mask_s[i] |
                             (free_valid[p] && (free_idx[p*IDX_W +: IDX_W] == IDX_W'(i)) && occ_r[i]);
            dbl_s = dbl_s |
                    (free_valid[p] && (free_idx[p*IDX_W +: IDX_W] == IDX_W'(i)) && !occ_r[i]);
         end
         dbl_s = dbl_s | (free_valid[p] & ~match_s[p]);
      end
      occ_next_s = (occ_r | fire_mask_s) & ~free_mask_s;
   end

   // Occupancy state: reset, then flush, then normal alloc/release update.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_r     <= '0;
         cnt_r     <= DEPTH_C;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
         dbl_err_r <= 1'b0;
      end else if (flush) begin
         occ_r     <= '0;
         cnt_r     <= DEPTH_C;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
         dbl_err_r <= dbl_err_r;
      end else begin
         occ_r     <= occ_next_s;
         cnt_r     <= DEPTH_C - popcount(occ_next_s);
         full_r    <= &occ_next_s;
         empty_r   <= ~|occ_next_s;
         dbl_err_r <= dbl_err_r | dbl_s;
      end
   end

   assign occupied        = occ_r;
   assign free_count      = cnt_r;
   assign full            = full_r;
   assign empty           = empty_r;
   assign double_free_err = dbl_err_r;

`ifdef RS_ALLOC_STATS_EN
   logic [31:0]    stall_r;
   logic [IDX_W:0] peak_r;
   logic [IDX_W:0] in_use_s;

   assign in_use_s = DEPTH_C - cnt_r;

   // Saturating stall counter and high-water mark; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_r <= '0;
         peak_r  <= '0;
      end else begin
         if (alloc_req[0] && !alloc_ready[0] && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
         end else begin
            stall_r <= stall_r;
         end
         peak_r <= (in_use_s > peak_r) ? in_use_s : peak_r;
      end
   end

   assign stall_cycles   = stall_r;
   assign peak_occupancy = peak_r;
`endif

endmodule

// File: tb/tb_rs_slot_allocator.sv
// Directed scoreboard bench for rs_slot_allocator (DEPTH=8, ALLOC_W=2, FREE_W=2).
// Stimulus pushes the hand-computed expectation for each cycle; a negedge
// monitor pops and compares against what the DUT presents.
module tb_rs_slot_allocator;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [1:0] alloc_req;
   logic [1:0] alloc_ready;
   logic [5:0] alloc_idx;
   logic [1:0] free_valid;
   logic [5:0] free_idx;
   logic [7:0] occupied;
   logic [3:0] free_count;
   logic       full;
   logic       empty;
   logic       double_free_err;
`ifdef RS_ALLOC_STATS_EN
   logic [31:0] stall_cycles;
   logic [3:0]  peak_occupancy;
`endif

   always #5 clk = ~clk;

   rs_slot_allocator #(.DEPTH(8), .ALLOC_W(2), .FREE_W(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .alloc_req       (alloc_req),
      .alloc_ready     (alloc_ready),
      .alloc_idx       (alloc_idx),
      .free_valid      (free_valid),
      .free_idx        (free_idx),
      .occupied        (occupied),
      .free_count      (free_count),
      .full            (full),
      .empty           (empty),
      .double_free_err (double_free_err)
`ifdef RS_ALLOC_STATS_EN
      ,
      .stall_cycles    (stall_cycles),
      .peak_occupancy  (peak_occupancy)
`endif
   );

   typedef struct {
      int         tag;
      logic [1:0] rdy;
      logic [1:0] fire;
      logic [2:0] i0;
      logic [2:0] i1;
      logic [7:0] occ;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s step=%0d got=%h want=%h", nm, tag, got, want);
      end
   endtask

   // Drive one cycle of inputs and queue the expected outputs for that cycle.
   task automatic step(input int tag, input logic rs, input logic fl, input logic [1:0] req,
                       input logic [1:0] fv, input logic [2:0] fi0, input logic [2:0] fi1,
                       input logic [1:0] e_rdy, input logic [1:0] e_fire,
                       input logic [2:0] e_i0, input logic [2:0] e_i1,
                       input logic [7:0] e_occ, input logic [3:0] e_cnt, input logic e_err);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = rs;
      flush      = fl;
      alloc_req  = req;
      free_valid = fv;
      free_idx   = {fi1, fi0};
      e.tag = tag; e.rdy = e_rdy; e.fire = e_fire; e.i0 = e_i0; e.i1 = e_i1;
      e.occ = e_occ; e.cnt = e_cnt; e.err = e_err;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs and observed grants with the queued expectation.
   initial begin
      exp_t       e;
      logic [1:0] obs_fire;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs_fire[0] = alloc_req[0] & alloc_ready[0];
            obs_fire[1] = obs_fire[0] & alloc_req[1] & alloc_ready[1];
            chk("alloc_ready", e.tag, 32'(alloc_ready), 32'(e.rdy));
            chk("grant",       e.tag, 32'(obs_fire),    32'(e.fire));
            chk("alloc_idx0",  e.tag, 32'(alloc_idx[2:0]), 32'(e.i0));
            chk("alloc_idx1",  e.tag, 32'(alloc_idx[5:3]), 32'(e.i1));
            chk("occupied",    e.tag, 32'(occupied),    32'(e.occ));
            chk("free_count",  e.tag, 32'(free_count),  32'(e.cnt));
            chk("full",        e.tag, 32'(full),        32'(e.cnt == 4'd0));
            chk("empty",       e.tag, 32'(empty),       32'(e.cnt == 4'd8));
            chk("double_free_err", e.tag, 32'(double_free_err), 32'(e.err));
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      reset = 1'b1; flush = 1'b0; alloc_req = 2'b00; free_valid = 2'b00; free_idx = 6'd0;
      //    tag rs  fl  req    fv     fi0   fi1    rdy    fire   i0    i1    occ     cnt   err
      step( 0, 1'b1,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b00,2'b00,3'd0,3'd0,8'h00,4'd8,1'b0);
      step( 1, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd0,3'd1,8'h00,4'd8,1'b0);
      step( 2, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd2,3'd3,8'h03,4'd6,1'b0);
      step( 3, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd4,3'd5,8'h0F,4'd4,1'b0);
      step( 4, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd6,3'd7,8'h3F,4'd2,1'b0);
      step( 5, 1'b0,1'b0,2'b11,2'b01,3'd3,3'd0, 2'b00,2'b00,3'd0,3'd0,8'hFF,4'd0,1'b0);
      step( 6, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b01,2'b01,3'd3,3'd0,8'hF7,4'd1,1'b0);
      step( 7, 1'b0,1'b0,2'b00,2'b11,3'd1,3'd3, 2'b00,2'b00,3'd0,3'd0,8'hFF,4'd0,1'b0);
      step( 8, 1'b0,1'b0,2'b10,2'b00,3'd0,3'd0, 2'b11,2'b00,3'd1,3'd3,8'hF5,4'd2,1'b0);
      step( 9, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd1,3'd3,8'hF5,4'd2,1'b0);
      step(10, 1'b0,1'b1,2'b00,2'b00,3'd0,3'd0, 2'b00,2'b00,3'd0,3'd0,8'hFF,4'd0,1'b0);
      step(11, 1'b0,1'b0,2'b01,2'b00,3'd0,3'd0, 2'b11,2'b01,3'd0,3'd1,8'h00,4'd8,1'b0);
      step(12, 1'b0,1'b0,2'b01,2'b01,3'd0,3'd0, 2'b11,2'b01,3'd1,3'd2,8'h01,4'd7,1'b0);
      step(13, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd0,3'd2,8'h02,4'd7,1'b0);
      step(14, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd3,3'd4,8'h07,4'd5,1'b0);
      step(15, 1'b0,1'b0,2'b01,2'b00,3'd0,3'd0, 2'b11,2'b01,3'd5,3'd6,8'h1F,4'd3,1'b0);
      step(16, 1'b0,1'b0,2'b00,2'b11,3'd5,3'd5, 2'b11,2'b00,3'd6,3'd7,8'h3F,4'd2,1'b0);
      step(17, 1'b0,1'b0,2'b00,2'b01,3'd5,3'd0, 2'b11,2'b00,3'd5,3'd6,8'h1F,4'd3,1'b0);
      step(18, 1'b0,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b11,2'b11,3'd5,3'd6,8'h1F,4'd3,1'b1);
      step(19, 1'b0,1'b0,2'b01,2'b11,3'd0,3'd1, 2'b01,2'b01,3'd7,3'd0,8'h7F,4'd1,1'b1);
      step(20, 1'b0,1'b0,2'b00,2'b11,3'd2,3'd3, 2'b11,2'b00,3'd0,3'd1,8'hFC,4'd2,1'b1);
      step(21, 1'b0,1'b1,2'b11,2'b01,3'd4,3'd0, 2'b00,2'b00,3'd0,3'd0,8'hF0,4'd4,1'b1);
      step(22, 1'b0,1'b0,2'b00,2'b00,3'd0,3'd0, 2'b11,2'b00,3'd0,3'd1,8'h00,4'd8,1'b1);
      step(23, 1'b1,1'b0,2'b11,2'b00,3'd0,3'd0, 2'b00,2'b00,3'd0,3'd0,8'h00,4'd8,1'b1);
      step(24, 1'b0,1'b0,2'b00,2'b00,3'd0,3'd0, 2'b11,2'b00,3'd0,3'd1,8'h00,4'd8,1'b0);

      // Let the monitor drain the queue within a bounded number of cycles.
      for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
         @(negedge clk);
      end
      #1;
      chk("queue_drained", 99, 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_slot_allocator.md
Name: rs_slot_allocator

Overview:
- Stateful slot allocator for a reservation station; generalises the single-cycle free-slot finder.
- Owns the occupancy mask of a DEPTH-entry RS.
- Each cycle it grants up to ALLOC_W lowest-index free slots to dispatch and retires up to FREE_W slots released by issue.
- Sits between rename/dispatch and the RS storage array; also supplies the free count used for dispatch back-pressure.

Parameters:
- DEPTH, 8, number of RS entries; at least 2.
- ALLOC_W, 2, dispatch lanes per cycle; 1 to 4, and ALLOC_W <= DEPTH.
- FREE_W, 2, issue-release ports per cycle; 1 to 4.
- IDX_W, $clog2(DEPTH), slot index width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  mispredict flush; clears all occupancy
- alloc_req  in  ALLOC_W  per-lane dispatch request; lane 0 is oldest
- alloc_ready  out  ALLOC_W  per-lane grant available (combinational from registered state)
- alloc_idx  out  ALLOC_W*IDX_W  slot index offered to each lane
- free_valid  in  FREE_W  per-port release strobe from issue
- free_idx  in  FREE_W*IDX_W  slot index being released
- occupied  out  DEPTH  registered occupancy mask; bit i=1 means entry i is in use
- free_count  out  IDX_W+1  registered number of free entries
- full  out  1  free_count==0
- empty  out  1  free_count==DEPTH
- double_free_err  out  1  sticky error flag

Behaviour:
- Reset (sync, active-high; clk and reset as named above):
  - occupied=0, free_count=DEPTH, full=0, empty=1, double_free_err=0.
  - alloc_ready=0 during the reset cycle.
- Offer:
  - alloc_idx[k] = index of the (k+1)-th lowest zero bit of occupied.
  - alloc_ready[k] = (free_count > k) && !flush && !reset.
  - Lanes whose offer is unavailable drive alloc_idx = 0.
- Prefix rule:
  - A lane fires only if alloc_req[k] && alloc_ready[k] and every lower lane also fires.
  - A request in lane k with lane k-1 idle or not fired is not granted (in-order dispatch).
- Release:
  - free_valid[p] clears bit free_idx[p] at the next edge.
  - Duplicate indices across ports in the same cycle clear the bit once and raise no error.
  - Releasing a bit that is already 0 is ignored for state, and sets double_free_err.
- Update at the clock edge:
  - occ_next = (occupied | fire_mask) & ~free_mask.
  - free_count <= DEPTH - popcount(occ_next); full and empty follow.
  - Latency: an allocated slot reads occupied=1 the next cycle.
  - A released slot becomes offerable the next cycle; same-cycle bypass is never allowed.
- Flush:
  - Highest priority below reset: occupied <= 0 and free_count <= DEPTH.
  - Allocs and frees in that cycle are discarded.
  - double_free_err is not cleared by flush; only reset clears it.
- Full: all alloc_ready=0 and the mask holds. Frees proceed normally.
- Index arithmetic: free_idx >= DEPTH (non-power-of-2 DEPTH) is ignored and sets double_free_err.
- No combinational path from alloc_req to alloc_ready or alloc_idx.

Optional Feature:
- Macro: RS_ALLOC_STATS_EN.
- When defined, adds outputs:
  - stall_cycles (32 bits): cycles with alloc_req[0]=1 and alloc_ready[0]=0.
  - peak_occupancy (IDX_W+1 bits): maximum of DEPTH-free_count seen.
  - Both reset to 0; stall_cycles saturates at all-ones; neither is affected by flush.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Test Plan (DEPTH=8, ALLOC_W=2, FREE_W=2):
- Release reset, req=2'b11 for 4 cycles -> grants {0,1},{2,3},{4,5},{6,7}; then full=1, free_count=0, alloc_ready=00.
- Full state, free_valid=01 with idx 3, req=11 -> next cycle only alloc_ready[0]=1 with alloc_idx[0]=3; lane 1 not granted; following cycle full=1 again.
- occupied=8'b1111_0101, req=2'b10 -> no grant (prefix rule), occupied unchanged; req=2'b11 -> idx {1,3}, occupied=8'hFF.
- Same-cycle free of slot 0 and req=01 with occupied=8'h01 -> grant idx 1 (not 0); next cycle occupied=8'h02.
- Free idx 5 twice on both ports with occupied bit 5=1 -> bit cleared, double_free_err=0; free idx 5 again -> double_free_err=1, held through flush.
- occupied=8'hF0, flush with req=11 and a free of idx 4 -> next cycle occupied=0, free_count=8, empty=1; no grants recorded.
